// File: rtl/jtdd_pkg.sv
// Shared definitions for the ROM-download SDRAM write path: entry field widths,
// the "no lane enabled" mask value and the write FSM state encoding.
package jtdd_pkg;

    localparam int DATA_W = 8;
    localparam int MASK_W = 2;

    // Active-low lane enables: both bits set means neither byte lane is written
    localparam logic [MASK_W-1:0] MASK_NONE = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } wr_state_e;

    function automatic int entry_width(input int addr_w);
        return addr_w + DATA_W + MASK_W;
    endfunction

endpackage

// File: rtl/jtdd_prog_fifo.sv
// Generic synchronous circular FIFO with an extra pointer MSB to tell full from
// empty. A pop in the same cycle frees a slot for a push; clear restarts it.
module jtdd_prog_fifo #(
    parameter int W          = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [W-1:0]          din,
    output logic [W-1:0]          dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int                DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [DEPTH_LOG2:0]   wptr_q, wptr_d;
    logic [DEPTH_LOG2:0]   rptr_q, rptr_d;
    logic [W-1:0]          mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] waddr;
    logic                  wr_en;
    logic                  rd_en;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                   (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
    assign level = wptr_q - rptr_q;
    assign dout  = mem_q[rptr_q[DEPTH_LOG2-1:0]];

    // A clear empties the FIFO first, so a push in that cycle always lands in slot 0
    assign rd_en = pop && !empty && !clear;
    assign wr_en = push && (clear || !full || rd_en);
    assign waddr = clear ? '0 : wptr_q[DEPTH_LOG2-1:0];

    // NOTE: every variable written in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clear) begin
            rptr_d = '0;
            wptr_d = wr_en ? PTR_ONE : '0;
        end else begin
            if (rd_en) rptr_d = rptr_q + PTR_ONE;
            if (wr_en) wptr_d = wptr_q + PTR_ONE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // NOTE: the storage array is not reset; the pointers alone define which slots
    // hold valid data, and leaving it reset-free lets it map to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[waddr] <= din;
    end

endmodule

// File: rtl/jtdd_prog_wr.sv
// Buffered SDRAM write stage for ROM download: queues byte writes, issues them one
// at a time over a req/ack handshake and stretches busy until the queue drains.
module jtdd_prog_wr
    import jtdd_pkg::*;
#(
    parameter int AW         = 22,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  downloading,
    input  logic [AW-1:0]         prog_addr,
    input  logic [DATA_W-1:0]     prog_data,
    input  logic [MASK_W-1:0]     prog_mask,
    input  logic                  prog_we,
    output logic                  sdram_wr_req,
    output logic [AW-1:0]         sdram_wr_addr,
    output logic [2*DATA_W-1:0]   sdram_din,
    output logic [MASK_W-1:0]     sdram_wr_mask,
    input  logic                  sdram_ack,
    output logic                  dwnld_busy,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int EW = entry_width(AW);

    wr_state_e           state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic                ovf_q, ovf_d;
    logic                dl_q;

    logic                dl_rise;
    logic                push_req;
    logic                pop;
    logic [EW-1:0]       fifo_din;
    logic [EW-1:0]       fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;
    logic [AW-1:0]       head_addr;
    logic [DATA_W-1:0]   head_data;
    logic [MASK_W-1:0]   head_mask;

    // A new download restarts the queue; the previous level is kept in dl_q
    assign dl_rise  = downloading && !dl_q;
    assign push_req = prog_we && (prog_mask != MASK_NONE);
    assign pop      = (state_q == ST_IDLE) && !fifo_empty && !dl_rise;

    assign fifo_din = {prog_addr, prog_data, prog_mask};
    assign {head_addr, head_data, head_mask} = fifo_dout;

    jtdd_prog_fifo #(
        .W          (EW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (dl_rise),
        .push  (push_req),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mask_d  = mask_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    addr_d  = head_addr;
                    data_d  = head_data;
                    mask_d  = head_mask;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (sdram_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A pop in the same cycle frees a slot, so only a push with no room is dropped
        if (dl_rise) begin
            ovf_d = 1'b0;
        end else if (push_req && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= MASK_NONE;
            ovf_q   <= 1'b0;
            dl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            ovf_q   <= ovf_d;
            dl_q    <= downloading;
        end
    end

    assign sdram_wr_req  = (state_q == ST_REQ);
    assign sdram_wr_addr = addr_q;
    assign sdram_din     = {data_q, data_q};
    assign sdram_wr_mask = mask_q;
    assign overflow      = ovf_q;
    assign dwnld_busy    = downloading || (level != '0) || (state_q == ST_REQ);

endmodule

// File: tb/tb_jtdd_prog_wr.sv
// Scoreboard bench for jtdd_prog_wr: a queue-based model predicts which writes reach
// SDRAM and in what order; a monitor compares every request and the status outputs.
module tb_jtdd_prog_wr;

    localparam int AW    = 22;
    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;

    logic            clk;
    logic            rst_n;
    logic            downloading;
    logic [AW-1:0]   prog_addr;
    logic [7:0]      prog_data;
    logic [1:0]      prog_mask;
    logic            prog_we;
    logic            sdram_wr_req;
    logic [AW-1:0]   sdram_wr_addr;
    logic [15:0]     sdram_din;
    logic [1:0]      sdram_wr_mask;
    logic            sdram_ack;
    logic            dwnld_busy;
    logic            overflow;
    logic [DL2:0]    level;

    jtdd_prog_wr #(.AW(AW), .DEPTH_LOG2(DL2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .downloading   (downloading),
        .prog_addr     (prog_addr),
        .prog_data     (prog_data),
        .prog_mask     (prog_mask),
        .prog_we       (prog_we),
        .sdram_wr_req  (sdram_wr_req),
        .sdram_wr_addr (sdram_wr_addr),
        .sdram_din     (sdram_din),
        .sdram_wr_mask (sdram_wr_mask),
        .sdram_ack     (sdram_ack),
        .dwnld_busy    (dwnld_busy),
        .overflow      (overflow),
        .level         (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic [1:0]    mask;
    } wr_t;

    // Reference model: an ordered queue of accepted writes plus an "in flight" flag
    wr_t mq[$];
    wr_t exp_q[$];
    bit  m_busy;
    bit  m_ovf;
    bit  m_dl_prev;

    always @(posedge clk or negedge rst_n) begin : model
        bit  rise;
        wr_t e;
        if (!rst_n) begin
            mq.delete();
            m_busy    = 1'b0;
            m_ovf     = 1'b0;
            m_dl_prev = 1'b0;
        end else begin
            rise      = downloading && !m_dl_prev;
            m_dl_prev = downloading;
            if (m_busy) begin
                if (sdram_ack) m_busy = 1'b0;
            end else if (mq.size() > 0 && !rise) begin
                exp_q.push_back(mq.pop_front());
                m_busy = 1'b1;
            end
            if (rise) begin
                mq.delete();
                m_ovf = 1'b0;
            end
            if (prog_we && prog_mask != 2'b11) begin
                if (mq.size() < DEPTH) begin
                    e.addr = prog_addr;
                    e.data = prog_data;
                    e.mask = prog_mask;
                    mq.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    // Monitor: a new request is a rising edge of req (there is always an idle gap)
    logic req_prev = 1'b0;
    wr_t  cur;
    int   writes_seen = 0;

    always @(posedge clk) begin : monitor
        #1;
        if (rst_n) begin
            check("req",      64'(sdram_wr_req), 64'(m_busy));
            check("level",    64'(level),        64'(mq.size()));
            check("overflow", 64'(overflow),     64'(m_ovf));
            check("busy",     64'(dwnld_busy),
                  64'(downloading || mq.size() != 0 || m_busy));
            if (sdram_wr_req && !req_prev) begin
                writes_seen++;
                check("wr_expected_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    check("wr_addr", 64'(sdram_wr_addr), 64'(cur.addr));
                    check("wr_din",  64'(sdram_din),     64'({cur.data, cur.data}));
                    check("wr_mask", 64'(sdram_wr_mask), 64'(cur.mask));
                end
            end else if (sdram_wr_req) begin
                check("hold_addr", 64'(sdram_wr_addr), 64'(cur.addr));
                check("hold_din",  64'(sdram_din),     64'({cur.data, cur.data}));
                check("hold_mask", 64'(sdram_wr_mask), 64'(cur.mask));
            end
            req_prev = sdram_wr_req;
        end else begin
            req_prev = 1'b0;
        end
    end

    // Ack driver: 0 = held low, 1 = held high, 2 = random, 3 = driven by the test
    int ack_mode = 0;
    always @(negedge clk) begin
        case (ack_mode)
            0:       sdram_ack = 1'b0;
            1:       sdram_ack = 1'b1;
            2:       sdram_ack = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    task automatic wr(input logic [AW-1:0] a, input logic [7:0] d, input logic [1:0] m);
        prog_addr = a;
        prog_data = d;
        prog_mask = m;
        prog_we   = 1'b1;
        @(negedge clk);
        prog_we   = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_download();
        downloading = 1'b0;
        @(negedge clk);
        downloading = 1'b1;
        cycles(2);
    endtask

    task automatic drain(input int limit);
        int k = 0;
        ack_mode = 1;
        while ((mq.size() != 0 || m_busy || exp_q.size() != 0) && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("drain_in_time", 64'(k < limit), 64'd1);
        cycles(2);
    endtask

    task automatic wait_req(input int limit);
        int k = 0;
        while (!sdram_wr_req && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("req_in_time", 64'(sdram_wr_req), 64'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int base;
        rst_n       = 1'b0;
        downloading = 1'b0;
        prog_we     = 1'b0;
        prog_addr   = '0;
        prog_data   = '0;
        prog_mask   = 2'b11;
        sdram_ack   = 1'b0;

        // Reset values, and busy following downloading combinationally
        #12;
        check("rst_req",      64'(sdram_wr_req),  64'd0);
        check("rst_addr",     64'(sdram_wr_addr), 64'd0);
        check("rst_din",      64'(sdram_din),     64'd0);
        check("rst_mask",     64'(sdram_wr_mask), 64'h3);
        check("rst_overflow", 64'(overflow),      64'd0);
        check("rst_level",    64'(level),         64'd0);
        check("rst_busy_lo",  64'(dwnld_busy),    64'd0);
        downloading = 1'b1;
        #1 check("rst_busy_hi", 64'(dwnld_busy), 64'd1);
        downloading = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);

        // Single write with ack three cycles into the request
        start_download();
        ack_mode  = 3;
        sdram_ack = 1'b0;
        wr(22'h05_0000, 8'hA5, 2'b10);
        check("single_queued_level", 64'(level),        64'd1);
        check("single_req_not_yet",  64'(sdram_wr_req), 64'd0);
        @(negedge clk);
        check("single_req",  64'(sdram_wr_req),  64'd1);
        check("single_addr", 64'(sdram_wr_addr), 64'h05_0000);
        check("single_din",  64'(sdram_din),     64'hA5A5);
        check("single_mask", 64'(sdram_wr_mask), 64'h2);
        cycles(2);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        check("single_req_dropped", 64'(sdram_wr_req), 64'd0);
        downloading = 1'b0;
        #1 check("single_busy_released", 64'(dwnld_busy), 64'd0);
        @(negedge clk);

        // Burst of 6 with ack held low: one in flight, four queued, one dropped
        start_download();
        ack_mode = 0;
        base = writes_seen;
        for (int i = 0; i < 6; i++) wr(AW'(32'h100 + i), 8'($urandom), 2'b10);
        cycles(1);
        check("burst_level_sat", 64'(level),    64'd4);
        check("burst_overflow",  64'(overflow), 64'd1);
        drain(100);
        check("burst_writes", 64'(writes_seen - base), 64'd5);

        // Pop and push in the same cycle while full: the push is accepted
        start_download();
        check("restart_clears_overflow", 64'(overflow), 64'd0);
        ack_mode = 0;
        base = writes_seen;
        for (int i = 0; i < 5; i++) wr(AW'(32'h200 + i), 8'($urandom), 2'b01);
        cycles(1);
        check("full_level", 64'(level), 64'd4);
        ack_mode  = 3;
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        wr(AW'(32'h205), 8'h3C, 2'b10);
        check("pushpop_no_overflow", 64'(overflow), 64'd0);
        check("pushpop_level",       64'(level),    64'd4);
        drain(100);
        check("pushpop_writes", 64'(writes_seen - base), 64'd6);

        // Mask 2'b11 is discarded silently; mask 2'b01 passes through
        ack_mode = 1;
        base = writes_seen;
        wr(AW'(32'h300), 8'h11, 2'b11);
        check("mask_none_level", 64'(level), 64'd0);
        cycles(2);
        check("mask_none_no_write", 64'(writes_seen - base), 64'd0);
        wr(AW'(32'h301), 8'h22, 2'b01);
        @(negedge clk);
        check("mask_hi_req",  64'(sdram_wr_req),  64'd1);
        check("mask_hi_mask", 64'(sdram_wr_mask), 64'h1);
        check("mask_hi_din",  64'(sdram_din),     64'h2222);
        cycles(2);

        // Busy outlives downloading until the last queued write is acknowledged
        ack_mode = 0;
        for (int i = 0; i < 3; i++) wr(AW'(32'h400 + i), 8'($urandom), 2'b10);
        cycles(2);
        downloading = 1'b0;
        cycles(3);
        check("tail_busy_held", 64'(dwnld_busy), 64'd1);
        ack_mode = 3;
        for (int i = 0; i < 3; i++) begin
            wait_req(20);
            check("tail_busy_before_ack", 64'(dwnld_busy), 64'd1);
            sdram_ack = 1'b1;
            @(negedge clk);
            sdram_ack = 1'b0;
        end
        check("tail_busy_dropped", 64'(dwnld_busy), 64'd0);
        cycles(2);

        // Asynchronous reset in the middle of a request
        start_download();
        ack_mode = 0;
        for (int i = 0; i < 6; i++) wr(AW'(32'h500 + i), 8'($urandom), 2'b10);
        cycles(1);
        check("pre_reset_overflow", 64'(overflow), 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_reset_req",      64'(sdram_wr_req),  64'd0);
        check("mid_reset_level",    64'(level),         64'd0);
        check("mid_reset_overflow", 64'(overflow),      64'd0);
        check("mid_reset_mask",     64'(sdram_wr_mask), 64'h3);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);
        base = writes_seen;
        wr(AW'(32'h1234), 8'h5A, 2'b10);
        drain(50);
        check("post_reset_writes", 64'(writes_seen - base), 64'd1);

        // Random traffic with random ack timing and occasional download restarts
        start_download();
        ack_mode = 2;
        for (int i = 0; i < 400; i++) begin
            prog_we   = 1'($urandom_range(0, 1));
            prog_addr = AW'($urandom);
            prog_data = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       prog_mask = 2'b11;
                1:       prog_mask = 2'b01;
                default: prog_mask = 2'b10;
            endcase
            if ($urandom_range(0, 99) < 2) downloading = ~downloading;
            @(negedge clk);
        end
        prog_we     = 1'b0;
        downloading = 1'b1;
        drain(200);
        downloading = 1'b0;
        cycles(2);
        check("final_idle_busy", 64'(dwnld_busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
